// File: rtl/fetch_unit_pw_pkg.sv
`default_nettype none
// fetch_unit_pw_pkg -- shared fetch-stage types: packet layout, FSM encoding, line geometry helper.
// Rev 1.0
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package fetch_unit_pw_pkg;

  localparam int unsigned PKG_FETCH_WIDTH = `FETCH_WIDTH;
  localparam int unsigned PKG_XLEN        = 32;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PKG_FETCH_WIDTH*32-1:0]       inst;
    logic [PKG_FETCH_WIDTH*PKG_XLEN-1:0] pc;
    logic [PKG_FETCH_WIDTH-1:0]          mask;
    logic [PKG_FETCH_WIDTH-1:0]          pred_taken;
    logic [PKG_XLEN-1:0]                 pred_target;
  } fetch_pkt_t;

  // Byte-offset width of a fetch line holding fetch_width 32-bit instructions.
  function automatic int unsigned line_off_bits(input int unsigned fetch_width);
    return $clog2(fetch_width) + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_slot_mask.sv
`default_nettype none
// fetch_slot_mask -- per-slot valid mask from line offset, truncated after the first predicted-taken slot.
// Rev 1.0
module fetch_slot_mask
  import fetch_unit_pw_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  logic [$clog2(FETCH_WIDTH)-1:0] off_i,
  input  logic [FETCH_WIDTH-1:0]         bp_taken_i,
  output logic [FETCH_WIDTH-1:0]         mask_o,
  output logic [FETCH_WIDTH-1:0]         pred_taken_o
);

  localparam int unsigned SLOT = $clog2(FETCH_WIDTH);

  always_comb begin
    logic blocked;
    mask_o       = '0;
    pred_taken_o = '0;
    blocked      = 1'b0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if ((SLOT'(i) >= off_i) && !blocked) begin
        mask_o[i] = 1'b1;
        if (bp_taken_i[i]) begin
          pred_taken_o[i] = 1'b1;
          blocked         = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit_pw.sv
`default_nettype none
// fetch_unit_pw -- fetch PC, single-outstanding I-cache request, masked line into a one-entry output register.
// Rev 1.0
module fetch_unit_pw
  import fetch_unit_pw_pkg::*;
#(
  parameter int unsigned     FETCH_WIDTH = 4,
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        icache_req_valid,
  input  logic                        icache_req_ready,
  output logic [XLEN-1:0]             icache_req_addr,
  input  logic                        icache_resp_valid,
  output logic                        icache_resp_ready,
  input  logic [FETCH_WIDTH*32-1:0]   icache_resp_data,
  output logic [XLEN-1:0]             bp_pc,
  input  logic [FETCH_WIDTH-1:0]      bp_taken,
  input  logic [XLEN-1:0]             bp_target,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FETCH_WIDTH*32-1:0]   out_inst,
  output logic [FETCH_WIDTH*XLEN-1:0] out_pc,
  output logic [FETCH_WIDTH-1:0]      out_mask,
  output logic [FETCH_WIDTH-1:0]      out_pred_taken,
  output logic [XLEN-1:0]             out_pred_target
);

  localparam int unsigned LINE_BYTES = FETCH_WIDTH * 4;
  localparam int unsigned OFF        = line_off_bits(FETCH_WIDTH);
  localparam int unsigned SLOT       = OFF - 2;

  localparam logic [1:0] ST_REQ  = FS_REQ;
  localparam logic [1:0] ST_WAIT = FS_WAIT;
  localparam logic [1:0] ST_DROP = FS_DROP;

  logic [1:0]                  state_q, state_d;
  logic [XLEN-1:0]             pc_q, pc_d;
  logic [XLEN-1:0]             req_pc_q, req_pc_d;
  logic                        out_valid_q, out_valid_d;
  logic [FETCH_WIDTH*32-1:0]   out_inst_q, out_inst_d;
  logic [FETCH_WIDTH*XLEN-1:0] out_pc_q, out_pc_d;
  logic [FETCH_WIDTH-1:0]      out_mask_q, out_mask_d;
  logic [FETCH_WIDTH-1:0]      out_pred_taken_q, out_pred_taken_d;
  logic [XLEN-1:0]             out_pred_target_q, out_pred_target_d;

  logic [XLEN-1:0]             w_line_base;
  logic [SLOT-1:0]             w_off;
  logic [FETCH_WIDTH-1:0]      w_mask;
  logic [FETCH_WIDTH-1:0]      w_pred_taken;
  logic                        w_any_taken;
  logic [XLEN-1:0]             w_next_pc;
  logic [FETCH_WIDTH*XLEN-1:0] w_slot_pc;
  logic                        w_req_fire;
  logic                        w_resp_fire;
  logic                        w_live_fire;
  logic                        w_unused_redirect_lsb;

  assign w_line_base = {req_pc_q[XLEN-1:OFF], {OFF{1'b0}}};
  assign w_off       = req_pc_q[OFF-1:2];

  fetch_slot_mask #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_slot_mask (
    .off_i        (w_off),
    .bp_taken_i   (bp_taken),
    .mask_o       (w_mask),
    .pred_taken_o (w_pred_taken)
  );

  assign w_any_taken = |w_pred_taken;
  assign w_next_pc   = w_any_taken ? {bp_target[XLEN-1:2], 2'b00}
                                   : w_line_base + XLEN'(LINE_BYTES);

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot_pc
    assign w_slot_pc[g*XLEN +: XLEN] = w_line_base + XLEN'(4 * g);
  end

  // Instruction-address alignment is architectural; low redirect bits carry no information.
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    icache_resp_ready = 1'b0;
    case (state_q)
      ST_WAIT: icache_resp_ready = ~out_valid_q | out_ready;
      ST_DROP: icache_resp_ready = 1'b1;
      default: icache_resp_ready = 1'b0;
    endcase
  end

  assign w_req_fire  = (state_q == ST_REQ) & icache_req_ready;
  assign w_resp_fire = icache_resp_valid & icache_resp_ready;
  assign w_live_fire = w_resp_fire & (state_q == ST_WAIT);

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    req_pc_d          = req_pc_q;
    out_valid_d       = out_valid_q;
    out_inst_d        = out_inst_q;
    out_pc_d          = out_pc_q;
    out_mask_d        = out_mask_q;
    out_pred_taken_d  = out_pred_taken_q;
    out_pred_target_d = out_pred_target_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_live_fire && !redirect_valid) begin
      out_valid_d       = 1'b1;
      out_inst_d        = icache_resp_data;
      out_pc_d          = w_slot_pc;
      out_mask_d        = w_mask;
      out_pred_taken_d  = w_pred_taken;
      out_pred_target_d = w_any_taken ? bp_target : '0;
    end

    case (state_q)
      ST_REQ: begin
        if (w_req_fire) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (w_live_fire) begin
          state_d = ST_REQ;
          pc_d    = w_next_pc;
        end
      end
      ST_DROP: begin
        if (w_resp_fire) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // A redirect squashes the packet and any request still owed a response.
    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      out_valid_d = 1'b0;
      case (state_q)
        ST_REQ:  state_d = w_req_fire ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = w_live_fire ? ST_REQ : ST_DROP;
        // The stale line arriving now already retires the outstanding request.
        ST_DROP: state_d = w_resp_fire ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_REQ;
      pc_q              <= {RESET_PC[XLEN-1:2], 2'b00};
      req_pc_q          <= '0;
      out_valid_q       <= 1'b0;
      out_inst_q        <= '0;
      out_pc_q          <= '0;
      out_mask_q        <= '0;
      out_pred_taken_q  <= '0;
      out_pred_target_q <= '0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      req_pc_q          <= req_pc_d;
      out_valid_q       <= out_valid_d;
      out_inst_q        <= out_inst_d;
      out_pc_q          <= out_pc_d;
      out_mask_q        <= out_mask_d;
      out_pred_taken_q  <= out_pred_taken_d;
      out_pred_target_q <= out_pred_target_d;
    end
  end

  assign icache_req_valid = (state_q == ST_REQ);
  assign icache_req_addr  = {pc_q[XLEN-1:OFF], {OFF{1'b0}}};
  assign bp_pc            = req_pc_q;
  assign out_valid        = out_valid_q;
  assign out_inst         = out_inst_q;
  assign out_pc           = out_pc_q;
  assign out_mask         = out_mask_q;
  assign out_pred_taken   = out_pred_taken_q;
  assign out_pred_target  = out_pred_target_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_pw.sv
`default_nettype none
// tb_fetch_unit_pw -- cache/predictor environment with a packet scoreboard for fetch_unit_pw.
// Rev 1.0
module tb_fetch_unit_pw;

  localparam int FW = 4;
  localparam int XL = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XL-1:0]   redirect_pc;
  logic            icache_req_valid;
  logic            icache_req_ready;
  logic [XL-1:0]   icache_req_addr;
  logic            icache_resp_valid;
  logic            icache_resp_ready;
  logic [FW*32-1:0] icache_resp_data;
  logic [XL-1:0]   bp_pc;
  logic [FW-1:0]   bp_taken;
  logic [XL-1:0]   bp_target;
  logic            out_valid;
  logic            out_ready;
  logic [FW*32-1:0] out_inst;
  logic [FW*XL-1:0] out_pc;
  logic [FW-1:0]   out_mask;
  logic [FW-1:0]   out_pred_taken;
  logic [XL-1:0]   out_pred_target;

  fetch_unit_pw #(
    .FETCH_WIDTH (FW),
    .XLEN        (XL),
    .RESET_PC    (32'h0)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_ready (icache_resp_ready),
    .icache_resp_data  (icache_resp_data),
    .bp_pc             (bp_pc),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .out_mask          (out_mask),
    .out_pred_taken    (out_pred_taken),
    .out_pred_target   (out_pred_target)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [127:0] inst;
    logic [127:0] pcs;
    logic [3:0]   mask;
    logic [3:0]   pred;
    logic [31:0]  tgt;
  } pkt_t;

  pkt_t        exp_pkt_q[$];
  logic [31:0] exp_pc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pkt_seen = 0;

  // Environment state
  logic        pending = 1'b0, stale = 1'b0;
  logic [31:0] pend_pc = '0;
  int          lat_cnt = 0;
  logic [3:0]  cur_tk;
  logic [31:0] cur_tg;
  logic        hold_valid = 1'b0, redir_prev = 1'b0;
  logic [127:0] hold_inst;
  logic [3:0]  hold_mask;

  // Scenario knobs
  int          lat_k = 1;
  logic        or_knob = 1'b1, rq_knob = 1'b1, rnd_mode = 1'b0;
  logic        redir_now = 1'b0;
  logic [31:0] redir_pc_k = '0;
  logic        arm_rr = 1'b0;
  logic [31:0] arm_rr_pc = '0;
  logic        arm_req = 1'b0;
  logic [31:0] arm_req_pc = '0, arm_req_tgt = '0;
  logic [31:0] bp_line = 32'hFFFF_FFF0;
  logic [3:0]  bp_tk = '0;
  logic [31:0] bp_tgt = '0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] line_data(input logic [31:0] base);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = {8'hC0 + 8'(i), base[23:0]};
    return d;
  endfunction

  task automatic bp_lookup(input logic [31:0] pc, output logic [3:0] tk, output logic [31:0] tg);
    if (rnd_mode) begin
      tk = (pc[5:4] == 2'b01) ? pc[9:6] : 4'b0;
      tg = (pc ^ 32'h0000_0A40) & 32'hFFFF_FFFC;
    end else if (pc[31:4] == bp_line[31:4]) begin
      tk = bp_tk;
      tg = bp_tgt;
    end else begin
      tk = '0;
      tg = '0;
    end
  endtask

  // Expected packet and next fetch pc for a line fetched at pc.
  task automatic model_line(input logic [31:0] pc, input logic [3:0] tk, input logic [31:0] tg,
                            output pkt_t e, output logic [31:0] npc);
    logic [31:0] base;
    logic        blocked;
    base    = {pc[31:4], 4'h0};
    e       = '0;
    blocked = 1'b0;
    e.inst  = line_data(base);
    for (int i = 0; i < 4; i++) begin
      e.pcs[32*i +: 32] = base + 32'(4 * i);
      if (i >= int'(pc[3:2]) && !blocked) begin
        e.mask[i] = 1'b1;
        if (tk[i]) begin
          e.pred[i] = 1'b1;
          blocked   = 1'b1;
        end
      end
    end
    e.tgt = (|e.pred) ? tg : 32'h0;
    npc   = (|e.pred) ? {tg[31:2], 2'b00} : base + 32'h10;
  endtask

  task automatic step();
    logic        rf, sf, of;
    logic [31:0] npc;
    pkt_t        e;
    @(negedge clock);
    if (redir_prev) check_eq("redir_clears_out", out_valid, 1'b0);
    if (hold_valid) begin
      check_eq("hold_inst", out_inst, hold_inst);
      check_eq("hold_mask", out_mask, hold_mask);
    end
    if (pending) check_eq("bp_pc", bp_pc, pend_pc);
    if (rnd_mode) begin
      out_ready        = ($urandom_range(0, 1) == 1);
      icache_req_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready        = or_knob;
      icache_req_ready = rq_knob;
    end
    icache_resp_valid = pending && (lat_cnt == 0);
    icache_resp_data  = pending ? line_data({pend_pc[31:4], 4'h0}) : '0;
    bp_lookup(pend_pc, cur_tk, cur_tg);
    bp_taken  = pending ? cur_tk : '0;
    bp_target = pending ? cur_tg : '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_pc_k;
      redir_now      = 1'b0;
    end else if (rnd_mode && $urandom_range(0, 19) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom_range(0, 32'hFFFF);
    end
    #1;
    if (arm_rr && icache_resp_valid && icache_resp_ready && !stale) begin
      redirect_valid = 1'b1;
      redirect_pc    = arm_rr_pc;
      arm_rr         = 1'b0;
      #1;
    end
    rf = icache_req_valid && icache_req_ready;
    sf = icache_resp_valid && icache_resp_ready;
    of = out_valid && out_ready;
    if (out_valid && !out_ready) check_eq("resp_ready_stall", icache_resp_ready, 1'b0);
    if (of) begin
      pkt_seen++;
      check_eq("pkt_expected", exp_pkt_q.size() != 0, 1'b1);
      if (exp_pkt_q.size() != 0) begin
        e = exp_pkt_q.pop_front();
        check_eq("out_inst", out_inst, e.inst);
        check_eq("out_pc", out_pc, e.pcs);
        check_eq("out_mask", out_mask, e.mask);
        check_eq("out_pred_taken", out_pred_taken, e.pred);
        check_eq("out_pred_target", out_pred_target, e.tgt);
      end
    end
    if (sf) begin
      if (!stale && !redirect_valid) begin
        model_line(pend_pc, cur_tk, cur_tg, e, npc);
        exp_pkt_q.push_back(e);
        exp_pc_q.push_back(npc);
      end
      pending = 1'b0;
      stale   = 1'b0;
    end
    if (rf) begin
      check_eq("req_expected", exp_pc_q.size() != 0, 1'b1);
      if (exp_pc_q.size() != 0) begin
        pend_pc = exp_pc_q.pop_front();
        check_eq("req_addr", icache_req_addr, {pend_pc[31:4], 4'h0});
      end
      pending = 1'b1;
      lat_cnt = (rnd_mode ? int'($urandom_range(1, 3)) : lat_k) - 1;
      if (arm_req && pend_pc == arm_req_pc) begin
        redir_now  = 1'b1;
        redir_pc_k = arm_req_tgt;
        arm_req    = 1'b0;
      end
    end else if (pending && lat_cnt > 0) begin
      lat_cnt--;
    end
    if (redirect_valid) begin
      exp_pkt_q.delete();
      exp_pc_q.delete();
      exp_pc_q.push_back(redirect_pc & 32'hFFFF_FFFC);
      if (pending) stale = 1'b1;
    end
    hold_valid = out_valid && !out_ready && !redirect_valid;
    hold_inst  = out_inst;
    hold_mask  = out_mask;
    redir_prev = redirect_valid;
  endtask

  task automatic run_pkts(input int n);
    int target;
    int budget;
    target = pkt_seen + n;
    budget = 0;
    while (pkt_seen < target && budget < 300) begin
      step();
      budget++;
    end
    check_eq("pkt_count", pkt_seen, target);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir_now  = 1'b1;
    redir_pc_k = pc;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;
    bp_taken          = '0;
    bp_target         = '0;
    out_ready         = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check_eq("rst_req_valid", icache_req_valid, 1'b1);
    check_eq("rst_req_addr", icache_req_addr, 32'h0);
    check_eq("rst_resp_ready", icache_resp_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_bp_pc", bp_pc, 32'h0);
    check_eq("rst_out_mask", out_mask, 4'h0);
    check_eq("rst_out_pred", {out_pred_taken, out_pred_target}, 36'h0);
    exp_pc_q.push_back(32'h0);

    // Straight-line fetch from reset, 1-cycle cache
    lat_k = 1; or_knob = 1'b1; rq_knob = 1'b1;
    run_pkts(3);

    // Mid-line redirect: leading slots masked off
    redirect_to(32'h108);
    run_pkts(2);

    // Predicted-taken slot truncates the line and steers the next fetch
    bp_line = 32'h40; bp_tk = 4'b0110; bp_tgt = 32'h200;
    redirect_to(32'h43);
    run_pkts(2);
    bp_tk = 4'b0000;

    // Backpressure with a response waiting in the cache
    redirect_to(32'h500);
    or_knob = 1'b0;
    repeat (10) step();
    check_eq("stall_out_valid", out_valid, 1'b1);
    or_knob = 1'b1;
    run_pkts(3);

    // Redirect while a packet is held against out_ready=0
    or_knob = 1'b0;
    repeat (4) step();
    redirect_to(32'h700);
    step();
    or_knob = 1'b1;
    run_pkts(1);

    // Redirect right after a handshake: the in-flight line is dropped
    lat_k = 3;
    redirect_to(32'h80);
    arm_req = 1'b1; arm_req_pc = 32'h80; arm_req_tgt = 32'h300;
    run_pkts(2);
    check_eq("arm_req_fired", arm_req, 1'b0);

    // Redirect on a response fire with out_ready low; then wrap at top of memory
    lat_k = 1;
    redirect_to(32'h600);
    or_knob = 1'b0;
    arm_rr = 1'b1; arm_rr_pc = 32'hFFFF_FFF0;
    for (int i = 0; i < 20 && arm_rr; i++) step();
    check_eq("arm_rr_fired", arm_rr, 1'b0);
    step();
    or_knob = 1'b1;
    run_pkts(2);

    // Randomised latency, backpressure, predictions and redirects
    redirect_to(32'h1000);
    rnd_mode = 1'b1;
    repeat (600) step();
    rnd_mode = 1'b0;
    or_knob  = 1'b1;
    lat_k    = 1;
    redirect_to(32'h2000);
    run_pkts(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
